// File: rtl/branch_hazard_ctrl.sv
// Stall/flush controller for branches resolved in ID. It stalls on a load producer
// still in EX (2 cycles) or MEM (1 cycle), flushes IF/ID on a taken branch and counts both events.
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beq,
  input  logic             bnq,
  input  logic [4:0]       IDRs,
  input  logic [4:0]       IDRt,
  input  logic [4:0]       EXRd,
  input  logic             EX_regwrite,
  input  logic             EX_memread,
  input  logic [4:0]       MEMRd,
  input  logic             MEM_memread,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic br;
  logic match_ex, match_mem;
  logic haz_ex, haz_mem;
  logic stall, flush;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  assign br        = beq | bnq;
  assign match_ex  = (EXRd  != 5'd0) && ((EXRd  == IDRs) || (EXRd  == IDRt));
  assign match_mem = (MEMRd != 5'd0) && ((MEMRd == IDRs) || (MEMRd == IDRt));
  assign haz_ex    = br && EX_regwrite && EX_memread && match_ex;
  assign haz_mem   = br && MEM_memread && match_mem;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through this block leaves state_d unassigned,
    // which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (haz_ex) state_d = STALL;
      STALL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: Mealy in IDLE, Moore in STALL, released entirely while in reset.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          stall = haz_ex || haz_mem;
          flush = br && !haz_ex && !haz_mem && branch_taken;
        end
        STALL:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall;
  assign ifid_flush  = flush;

  // Performance counters saturate instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall && (stall_cycles_q != CNT_MAX)) stall_cycles_d = stall_cycles_q + 1'b1;
    if (flush && (flush_count_q  != CNT_MAX)) flush_count_d  = flush_count_q  + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed self-checking bench for branch_hazard_ctrl: a 16-bit counter instance
// plus a 2-bit counter instance sharing the same stimulus for saturation checks.
module tb_branch_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        beq, bnq;
  logic [4:0]  IDRs, IDRt, EXRd, MEMRd;
  logic        EX_regwrite, EX_memread, MEM_memread, branch_taken;

  logic        pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [15:0] stall_cycles, flush_count;
  logic        s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush;
  logic [1:0]  s_stall_cycles, s_flush_count;

  logic [3:0]  ctl;
  assign ctl = {pc_write, ifid_write, idex_bubble, ifid_flush};

  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] STL   = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1101;

  int checks   = 0;
  int failures = 0;

  branch_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .beq(beq), .bnq(bnq), .IDRs(IDRs), .IDRt(IDRt),
    .EXRd(EXRd), .EX_regwrite(EX_regwrite), .EX_memread(EX_memread),
    .MEMRd(MEMRd), .MEM_memread(MEM_memread), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  branch_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .beq(beq), .bnq(bnq), .IDRs(IDRs), .IDRt(IDRt),
    .EXRd(EXRd), .EX_regwrite(EX_regwrite), .EX_memread(EX_memread),
    .MEMRd(MEMRd), .MEM_memread(MEM_memread), .branch_taken(branch_taken),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_bubble(s_idex_bubble),
    .ifid_flush(s_ifid_flush), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    beq = 0; bnq = 0; IDRs = 0; IDRt = 0; EXRd = 0; MEMRd = 0;
    EX_regwrite = 0; EX_memread = 0; MEM_memread = 0; branch_taken = 0;
  endtask

  task automatic apply_reset();
    rst = 0;
    clear_inputs();
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    checks++; if (ctl !== RUN) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, RUN); end
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cycles); end
    checks++; if (flush_count !== 16'd0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_count); end
    // A hazard and a taken branch presented during reset must not stall or flush.
    beq = 1; IDRs = 5; EXRd = 5; EX_regwrite = 1; EX_memread = 1; branch_taken = 1;
    @(negedge clk);
    checks++; if (ctl !== RUN) begin failures++; $display("FAIL reset_hold_ctl got=%b exp=%b", ctl, RUN); end
    tick();
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_hold_cnt got=%0d exp=0", stall_cycles); end
    rst = 1;
    clear_inputs();
  endtask

  task automatic test_ex_load_hazard();
    apply_reset();
    beq = 1; IDRs = 5; EXRd = 5; EX_regwrite = 1; EX_memread = 1;
    @(negedge clk);
    checks++; if (ctl !== STL) begin failures++; $display("FAIL ex_t0_ctl got=%b exp=%b", ctl, STL); end
    tick();
    // Load moves to MEM; in STALL the hazard and taken inputs are ignored.
    EXRd = 0; EX_regwrite = 0; EX_memread = 0; MEMRd = 5; MEM_memread = 1; branch_taken = 1;
    @(negedge clk);
    checks++; if (ctl !== STL) begin failures++; $display("FAIL ex_t1_ctl got=%b exp=%b", ctl, STL); end
    tick();
    MEMRd = 0; MEM_memread = 0; branch_taken = 1;
    @(negedge clk);
    checks++; if (ctl !== FLUSH) begin failures++; $display("FAIL ex_t2_ctl got=%b exp=%b", ctl, FLUSH); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (ctl !== RUN) begin failures++; $display("FAIL ex_t3_ctl got=%b exp=%b", ctl, RUN); end
    checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL ex_stall_cnt got=%0d exp=2", stall_cycles); end
    checks++; if (flush_count !== 16'd1) begin failures++; $display("FAIL ex_flush_cnt got=%0d exp=1", flush_count); end
  endtask

  task automatic test_mem_load_hazard();
    apply_reset();
    bnq = 1; IDRt = 7; MEMRd = 7; MEM_memread = 1;
    @(negedge clk);
    checks++; if (ctl !== STL) begin failures++; $display("FAIL mem_t0_ctl got=%b exp=%b", ctl, STL); end
    tick();
    MEMRd = 0; MEM_memread = 0; branch_taken = 0;
    @(negedge clk);
    checks++; if (ctl !== RUN) begin failures++; $display("FAIL mem_t1_ctl got=%b exp=%b", ctl, RUN); end
    tick();
    clear_inputs();
    checks++; if (stall_cycles !== 16'd1) begin failures++; $display("FAIL mem_stall_cnt got=%0d exp=1", stall_cycles); end
    checks++; if (flush_count !== 16'd0) begin failures++; $display("FAIL mem_flush_cnt got=%0d exp=0", flush_count); end
  endtask

  task automatic test_no_hazard_cases();
    apply_reset();
    // ALU producer in EX is forwarded: no stall, taken branch flushes immediately.
    beq = 1; IDRs = 3; EXRd = 3; EX_regwrite = 1; EX_memread = 0; branch_taken = 1;
    @(negedge clk);
    checks++; if (ctl !== FLUSH) begin failures++; $display("FAIL alu_fwd_ctl got=%b exp=%b", ctl, FLUSH); end
    tick();
    // Register 0 never creates a hazard.
    IDRs = 0; IDRt = 0; EXRd = 0; EX_memread = 1; MEMRd = 0; MEM_memread = 1; branch_taken = 0;
    @(negedge clk);
    checks++; if (ctl !== RUN) begin failures++; $display("FAIL r0_ctl got=%b exp=%b", ctl, RUN); end
    tick();
    // Without a branch every hazard and taken input is ignored.
    beq = 0; IDRs = 5; EXRd = 5; MEMRd = 5; branch_taken = 1;
    @(negedge clk);
    checks++; if (ctl !== RUN) begin failures++; $display("FAIL nobr_ctl got=%b exp=%b", ctl, RUN); end
    tick();
    // beq and bnq together act as one branch.
    clear_inputs();
    beq = 1; bnq = 1; branch_taken = 1;
    @(negedge clk);
    checks++; if (ctl !== FLUSH) begin failures++; $display("FAIL both_br_ctl got=%b exp=%b", ctl, FLUSH); end
    tick();
    clear_inputs();
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL nohaz_stall_cnt got=%0d exp=0", stall_cycles); end
    checks++; if (flush_count !== 16'd2) begin failures++; $display("FAIL nohaz_flush_cnt got=%0d exp=2", flush_count); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    beq = 1; IDRs = 4; IDRt = 6; EXRd = 4; EX_regwrite = 1; EX_memread = 1; MEMRd = 6; MEM_memread = 1;
    @(negedge clk);
    checks++; if (ctl !== STL) begin failures++; $display("FAIL both_haz_t0_ctl got=%b exp=%b", ctl, STL); end
    tick();
    @(negedge clk);
    checks++; if (ctl !== STL) begin failures++; $display("FAIL both_haz_t1_ctl got=%b exp=%b", ctl, STL); end
    tick();
    EX_memread = 0; MEM_memread = 0; branch_taken = 0;
    @(negedge clk);
    checks++; if (ctl !== RUN) begin failures++; $display("FAIL both_haz_t2_ctl got=%b exp=%b", ctl, RUN); end
    checks++; if (stall_cycles !== 16'd2) begin failures++; $display("FAIL both_haz_cnt got=%0d exp=2", stall_cycles); end
    tick();
    // New load-in-EX hazard, then reset while in STALL.
    EX_memread = 1;
    @(negedge clk);
    checks++; if (ctl !== STL) begin failures++; $display("FAIL rst_stall_t0_ctl got=%b exp=%b", ctl, STL); end
    tick();
    rst = 0;
    @(negedge clk);
    checks++; if (ctl !== RUN) begin failures++; $display("FAIL rst_in_stall_ctl got=%b exp=%b", ctl, RUN); end
    tick();
    // After reset the FSM is IDLE: a non-hazard taken branch flushes at once.
    rst = 1;
    clear_inputs();
    beq = 1; branch_taken = 1;
    @(negedge clk);
    checks++; if (ctl !== FLUSH) begin failures++; $display("FAIL post_rst_ctl got=%b exp=%b", ctl, FLUSH); end
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL post_rst_stall_cnt got=%0d exp=0", stall_cycles); end
    checks++; if (flush_count !== 16'd0) begin failures++; $display("FAIL post_rst_flush_cnt got=%0d exp=0", flush_count); end
    tick();
    clear_inputs();
    checks++; if (flush_count !== 16'd1) begin failures++; $display("FAIL post_rst_flush1 got=%0d exp=1", flush_count); end
  endtask

  task automatic test_saturation();
    apply_reset();
    beq = 1; IDRs = 2; MEMRd = 2; MEM_memread = 1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (s_stall_cycles !== 2'd3) begin failures++; $display("FAIL sat_stall_reach got=%0d exp=3", s_stall_cycles); end
    for (int i = 0; i < 2; i++) tick();
    checks++; if (s_stall_cycles !== 2'd3) begin failures++; $display("FAIL sat_stall_hold got=%0d exp=3", s_stall_cycles); end
    checks++; if (stall_cycles !== 16'd5) begin failures++; $display("FAIL wide_stall_cnt got=%0d exp=5", stall_cycles); end
    MEM_memread = 0; branch_taken = 1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (s_flush_count !== 2'd3) begin failures++; $display("FAIL sat_flush_hold got=%0d exp=3", s_flush_count); end
    checks++; if (flush_count !== 16'd5) begin failures++; $display("FAIL wide_flush_cnt got=%0d exp=5", flush_count); end
    clear_inputs();
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_ex_load_hazard();
    test_mem_load_hazard();
    test_no_hazard_cases();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
